// File: rtl/smg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : smg_scan_ctrl_if
// Description : Bundle of application-side data/control inputs and board-side
//               display outputs for smg_scan_ctrl.
//               master : application / board view (drives data, reads pins)
//               slave  : the scan controller itself
// Signals     : num_data[4*DIG_NUM], dp_in[DIG_NUM], load, lz_blank_en,
//               bright[4], scan_sig[DIG_NUM], smg_data[8], frame_done,
//               test_mode (only when SMG_SELFTEST_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
interface smg_scan_ctrl_if #(
  parameter int DIG_NUM = 6
);
  logic [4*DIG_NUM-1:0] num_data;
  logic [DIG_NUM-1:0]   dp_in;
  logic                 load;
  logic                 lz_blank_en;
  logic [3:0]           bright;
`ifdef SMG_SELFTEST_EN
  logic                 test_mode;
`endif
  logic [DIG_NUM-1:0]   scan_sig;
  logic [7:0]           smg_data;
  logic                 frame_done;

  modport master (
`ifdef SMG_SELFTEST_EN
    output test_mode,
`endif
    output num_data, dp_in, load, lz_blank_en, bright,
    input  scan_sig, smg_data, frame_done
  );

  modport slave (
`ifdef SMG_SELFTEST_EN
    input  test_mode,
`endif
    input  num_data, dp_in, load, lz_blank_en, bright,
    output scan_sig, smg_data, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/smg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : smg_scan_ctrl
// Description : Multiplexed 7-segment display scan controller. Hex decode with
//               per-digit decimal points, optional leading-zero blanking,
//               16-level PWM brightness and double-buffered value updates that
//               take effect only at frame boundaries.
// Ports       : clk        - system clock
//               rst        - synchronous reset, active-high
//               bus        - smg_scan_ctrl_if.slave (data in, load strobe,
//                            blanking enable, brightness, digit select,
//                            segment data, frame_done pulse)
// Option      : SMG_SELFTEST_EN - adds bus.test_mode (all segments lit,
//               full duty, no blanking while high)
// Revision    : 1.0 - initial release
// ============================================================================
module smg_scan_ctrl #(
  parameter int DIG_NUM      = 6,
  parameter int SCAN_CNT     = 50000,
  parameter int CNT_W        = 16,
  parameter int SEG_ACT_LOW  = 1,
  parameter int SCAN_ACT_LOW = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  smg_scan_ctrl_if.slave    bus
);

  localparam int IDX_W = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
  localparam int THR_W = CNT_W + 5;

  localparam logic [CNT_W-1:0]   C_CNT_LAST  = CNT_W'(SCAN_CNT - 1);
  localparam logic [IDX_W-1:0]   C_IDX_LAST  = IDX_W'(DIG_NUM - 1);
  localparam logic [THR_W-1:0]   C_SLOT16    = THR_W'(SCAN_CNT / 16);
  localparam logic [7:0]         C_SEG_BLANK = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIG_NUM-1:0] C_SCAN_OFF  = (SCAN_ACT_LOW != 0) ? {DIG_NUM{1'b1}}
                                                                   : {DIG_NUM{1'b0}};

  // Active-low segment code {dp,g,f,e,d,c,b,a}, dp off.
  function automatic logic [7:0] f_hex(input logic [3:0] n);
    case (n)
      4'h0: f_hex = 8'hC0;  4'h1: f_hex = 8'hF9;
      4'h2: f_hex = 8'hA4;  4'h3: f_hex = 8'hB0;
      4'h4: f_hex = 8'h99;  4'h5: f_hex = 8'h92;
      4'h6: f_hex = 8'h82;  4'h7: f_hex = 8'hF8;
      4'h8: f_hex = 8'h80;  4'h9: f_hex = 8'h90;
      4'hA: f_hex = 8'h88;  4'hB: f_hex = 8'h83;
      4'hC: f_hex = 8'hC6;  4'hD: f_hex = 8'hA1;
      4'hE: f_hex = 8'h86;  default: f_hex = 8'h8E;
    endcase
  endfunction

  // State
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [IDX_W-1:0]     idx_q,      idx_d;
  logic [4*DIG_NUM-1:0] pend_num_q, pend_num_d;
  logic [DIG_NUM-1:0]   pend_dp_q,  pend_dp_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [4*DIG_NUM-1:0] act_num_q,  act_num_d;
  logic [DIG_NUM-1:0]   act_dp_q,   act_dp_d;
  logic                 fdone_q,    fdone_d;
  logic [DIG_NUM-1:0]   scan_q,     scan_d;
  logic [7:0]           seg_q,      seg_d;

  // Combinational helpers
  logic                 w_tick;
  logic                 w_bound;
  logic                 w_on;
  logic                 w_test;
  logic [THR_W-1:0]     w_thr;
  logic                 w_hi_zero;
  logic [3:0]           w_sel_nib;
  logic                 w_sel_dp;
  logic                 w_sel_blank;
  logic [7:0]           w_seg_low;
  logic [DIG_NUM-1:0]   w_onehot;

`ifdef SMG_SELFTEST_EN
  assign w_test = bus.test_mode;
`else
  assign w_test = 1'b0;
`endif

  always_comb begin
    // Slot timing
    w_tick  = (cnt_q == C_CNT_LAST);
    w_bound = w_tick && (idx_q == C_IDX_LAST);
    cnt_d   = w_tick ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    if (w_tick) begin
      idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // Double buffer: the boundary transfer reads pending as it was before this
    // edge; a load in the same cycle then refills pending for the next frame.
    pend_num_d = pend_num_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    act_num_d  = act_num_q;
    act_dp_d   = act_dp_q;
    if (w_bound && pend_vld_q) begin
      act_num_d  = pend_num_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
    end
    if (bus.load) begin
      pend_num_d = bus.num_data;
      pend_dp_d  = bus.dp_in;
      pend_vld_d = 1'b1;
    end
    fdone_d = w_bound;

    // Brightness window: first (bright+1)/16 of each slot is lit.
    w_thr = ({{CNT_W{1'b0}}, 1'b0, bus.bright} + THR_W'(1)) * C_SLOT16;
    w_on  = ({5'b0, cnt_q} < w_thr) || w_test;

    // Walk from the most significant digit down so w_hi_zero holds "this digit
    // and every higher one is zero" at the point the current digit is reached.
    w_hi_zero   = 1'b1;
    w_sel_nib   = 4'h0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    for (int k = DIG_NUM - 1; k >= 0; k--) begin
      w_hi_zero = w_hi_zero && (act_num_q[4*k +: 4] == 4'h0);
      if (idx_q == IDX_W'(k)) begin
        w_sel_nib   = act_num_q[4*k +: 4];
        w_sel_dp    = act_dp_q[k];
        w_sel_blank = w_hi_zero && (k != 0);
      end
    end

    w_seg_low = (bus.lz_blank_en && w_sel_blank) ? 8'hFF : f_hex(w_sel_nib);
    if (w_sel_dp) begin
      w_seg_low[7] = 1'b0;
    end
    if (w_test) begin
      w_seg_low = 8'h00;
    end

    w_onehot = DIG_NUM'(1) << idx_q;

    // Both pin groups are registered from the same state so they switch together.
    if (w_on) begin
      scan_d = (SCAN_ACT_LOW != 0) ? ~w_onehot : w_onehot;
      seg_d  = (SEG_ACT_LOW != 0) ? w_seg_low : ~w_seg_low;
    end else begin
      scan_d = C_SCAN_OFF;
      seg_d  = C_SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_num_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      act_num_q  <= '0;
      act_dp_q   <= '0;
      fdone_q    <= 1'b0;
      scan_q     <= C_SCAN_OFF;
      seg_q      <= C_SEG_BLANK;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_num_q <= pend_num_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      act_num_q  <= act_num_d;
      act_dp_q   <= act_dp_d;
      fdone_q    <= fdone_d;
      scan_q     <= scan_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.scan_sig   = scan_q;
  assign bus.smg_data   = seg_q;
  assign bus.frame_done = fdone_q;

endmodule
`default_nettype wire
